// File: rtl/caesar_clk_gate_pkg.sv
// rtl/caesar_clk_gate_pkg.sv - shared types and defaults for the caesar clock-gate controller
package caesar_clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_ON        = 2'd0,
        CG_IDLE_WAIT = 2'd1,
        CG_GATED     = 2'd2,
        CG_WAKE      = 2'd3
    } caesar_cg_state_e;

    localparam int CAESAR_CG_IDLE_CYCLES = 16;
    localparam int CAESAR_CG_WAKE_CYCLES = 2;

    // Width of the shared idle/wake down-counter; never narrower than one bit.
    function automatic int cg_cnt_width(input int idle_cycles, input int wake_cycles);
        int max_cycles;
        int w;
        max_cycles = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        w = $clog2(max_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/caesar_cg_sat_counter.sv
// rtl/caesar_cg_sat_counter.sv - saturating up-counter with synchronous clear and enable
module caesar_cg_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // Clear wins over increment; the count sticks at all-ones once reached.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/caesar_clk_gate_ctrl.sv
// rtl/caesar_clk_gate_ctrl.sv - idle-hysteresis enable controller for the caesar clock gate
module caesar_clk_gate_ctrl
    import caesar_clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = CAESAR_CG_IDLE_CYCLES,
    parameter int WAKE_CYCLES = CAESAR_CG_WAKE_CYCLES,
    parameter int STAT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              busy_i,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic              force_en_i,
    output logic              clk_en_o,
    output logic              gated_o,
    input  logic              stat_clr_i,
    output logic [STAT_W-1:0] gated_cycles_o
);

    localparam int              CNT_W     = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    caesar_cg_state_e state;
    logic [CNT_W-1:0] cnt;
    logic             clk_en_q;
    logic             gated_q;
    logic             act;

    // busy_i is deliberately left out of the wake condition: caesar cannot
    // raise it while its clock is stopped.
    assign act = busy_i | req_i | force_en_i;

    // State, hysteresis counter and the gate enable, all decoded into flops so
    // the enable pin of the gating cell only ever changes on a clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= CG_ON;
            cnt      <= '0;
            clk_en_q <= 1'b1;
            gated_q  <= 1'b0;
        end else begin
            unique case (state)
                CG_ON: begin
                    if (!act) begin
                        state <= CG_IDLE_WAIT;
                        cnt   <= IDLE_LOAD;
                    end
                end
                CG_IDLE_WAIT: begin
                    if (act) begin
                        state <= CG_ON;
                    end else if (cnt == '0) begin
                        state    <= CG_GATED;
                        clk_en_q <= 1'b0;
                        gated_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CG_GATED: begin
                    if (req_i || force_en_i) begin
                        state    <= CG_WAKE;
                        cnt      <= WAKE_LOAD;
                        clk_en_q <= 1'b1;
                        gated_q  <= 1'b0;
                    end
                end
                CG_WAKE: begin
                    if (cnt == '0) begin
                        state <= CG_ON;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= CG_ON;
                    cnt      <= '0;
                    clk_en_q <= 1'b1;
                    gated_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_en_o = clk_en_q;
    assign gated_o  = gated_q;

    // Zero-latency grant whenever the clock is already running and settled.
    assign gnt_o = req_i & ((state == CG_ON) | (state == CG_IDLE_WAIT));

    caesar_cg_sat_counter #(
        .W (STAT_W)
    ) u_gated_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (stat_clr_i),
        .en    (gated_q),
        .count (gated_cycles_o)
    );

endmodule

// File: tb/tb_caesar_clk_gate_ctrl.sv
// tb/tb_caesar_clk_gate_ctrl.sv - directed self-checking bench for caesar_clk_gate_ctrl
module tb_caesar_clk_gate_ctrl;

    logic        clk;
    logic        rst_i;
    logic        busy_i;
    logic        req_i;
    logic        force_en_i;
    logic        stat_clr_i;
    logic        gnt_o, clk_en_o, gated_o;
    logic [31:0] gated_cycles_o;
    logic        gnt4, clk_en4, gated4;
    logic [3:0]  gated_cycles4;

    int n_checks = 0;
    int n_fail   = 0;

    caesar_clk_gate_ctrl #(
        .IDLE_CYCLES (16),
        .WAKE_CYCLES (2),
        .STAT_W      (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .busy_i         (busy_i),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .force_en_i     (force_en_i),
        .clk_en_o       (clk_en_o),
        .gated_o        (gated_o),
        .stat_clr_i     (stat_clr_i),
        .gated_cycles_o (gated_cycles_o)
    );

    caesar_clk_gate_ctrl #(
        .IDLE_CYCLES (16),
        .WAKE_CYCLES (2),
        .STAT_W      (4)
    ) dut4 (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .busy_i         (busy_i),
        .req_i          (req_i),
        .gnt_o          (gnt4),
        .force_en_i     (force_en_i),
        .clk_en_o       (clk_en4),
        .gated_o        (gated4),
        .stat_clr_i     (stat_clr_i),
        .gated_cycles_o (gated_cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   reps;
        logic busy;
        logic req;
        logic frc;
        logic clr;
        logic en;
        logic gated;
        logic gnt;
        int   stat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, check outputs at the falling edge.
    task automatic cyc(input logic b, input logic r, input logic f, input logic c, input logic rs,
                       input logic e_en, input logic e_g, input logic e_gnt,
                       input int e_stat, input string nm);
        busy_i     = b;
        req_i      = r;
        force_en_i = f;
        stat_clr_i = c;
        rst_i      = rs;
        @(negedge clk);
        chk({nm, " clk_en"}, 32'(clk_en_o), 32'(e_en));
        chk({nm, " gated"},  32'(gated_o),  32'(e_g));
        chk({nm, " gnt"},    32'(gnt_o),    32'(e_gnt));
        chk({nm, " clk_en4"}, 32'(clk_en4), 32'(e_en));
        if (e_stat >= 0) begin
            chk({nm, " stat"},  gated_cycles_o, 32'(e_stat));
            chk({nm, " stat4"}, 32'(gated_cycles4), 32'((e_stat > 15) ? 15 : e_stat));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; busy_i = 1'b0; req_i = 1'b0; force_en_i = 1'b0; stat_clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    function automatic vec_t mk(input int n, input logic b, input logic r, input logic f,
                                input logic c, input logic en, input logic g, input logic gn,
                                input int st);
        vec_t v;
        v.reps = n; v.busy = b; v.req = r; v.frc = f; v.clr = c;
        v.en = en; v.gated = g; v.gnt = gn; v.stat = st;
        return v;
    endfunction

    initial begin
        // reset, gating after 16 idle cycles, wake on request, force override
        tbl.push_back(mk(1,   0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(16,  0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1,   0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(4,   0, 0, 0, 0, 0, 1, 0, 4));
        tbl.push_back(mk(1,   0, 1, 0, 0, 0, 1, 0, 5));
        tbl.push_back(mk(2,   0, 1, 0, 0, 1, 0, 0, 6));
        tbl.push_back(mk(1,   0, 1, 0, 0, 1, 0, 1, 6));
        tbl.push_back(mk(1,   1, 0, 0, 0, 1, 0, 0, 6));
        tbl.push_back(mk(100, 0, 0, 1, 0, 1, 0, 0, 6));
        tbl.push_back(mk(17,  0, 0, 0, 0, 1, 0, 0, 6));
        tbl.push_back(mk(1,   0, 0, 0, 0, 0, 1, 0, 6));
        tbl.push_back(mk(2,   0, 0, 0, 0, 0, 1, 0, 8));
        tbl.push_back(mk(1,   0, 0, 1, 0, 0, 1, 0, 9));
        tbl.push_back(mk(2,   0, 0, 0, 0, 1, 0, 0, 10));
        tbl.push_back(mk(1,   0, 0, 0, 0, 1, 0, 0, 10));
        tbl.push_back(mk(1,   0, 0, 0, 0, 1, 0, 0, 10));
        tbl.push_back(mk(1,   0, 1, 0, 0, 1, 0, 1, 10));
        tbl.push_back(mk(1,   0, 0, 0, 0, 1, 0, 0, 10));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                cyc(tbl[i].busy, tbl[i].req, tbl[i].frc, tbl[i].clr, 1'b0,
                    tbl[i].en, tbl[i].gated, tbl[i].gnt,
                    (r == tbl[i].reps - 1) ? tbl[i].stat : -1,
                    $sformatf("tbl[%0d].%0d", i, r));
            end
        end

        // idle abort exactly when the hysteresis would expire
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, "abort on");
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, $sformatf("abort iw%0d", i));
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, "abort iw15 busy");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, "abort back on");
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, $sformatf("rerun iw%0d", i));
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, "rerun gated");

        // saturation of the 4-bit copy, clear while gated, then reset from GATED
        for (int k = 1; k <= 21; k++) cyc(0, 0, 0, 0, 0, 0, 1, 0, k, $sformatf("sat k%0d", k));
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 22, "clr k22");
        for (int k = 23; k <= 62; k++) cyc(0, 0, 0, 0, 0, 0, 1, 0, k - 23, $sformatf("post clr k%0d", k));
        cyc(0, 0, 0, 0, 1, 0, 1, 0, 40, "rst in gated");
        cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, "after rst no wake");
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, "after rst on");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/caesar_clk_gate_ctrl.md
# caesar_clk_gate_ctrl

Sequential enable controller for the caesar clock gate: watches caesar activity and incoming bus requests, gates the caesar clock after a programmable idle hysteresis, and reopens it with a settle window before granting new requests. It runs on the free-running (ungated) clock, and its `clk_en_o` drives the enable pin of the caesar clock-gating cell. It also keeps a saturating count of gated cycles for power accounting.

## Interface
Parameters:
- `IDLE_CYCLES`, 16: consecutive idle cycles required before gating; legal range ≥1.
- `WAKE_CYCLES`, 2: settle cycles after re-enabling before grant; legal range ≥1.
- `STAT_W`, 32: width of the gated-cycle counter.

Ports:
- `clk_i`, in, 1: free-running, ungated clock. One clock; reset is synchronous and active-high.
- `rst_i`, in, 1: synchronous, active-high reset.
- `busy_i`, in, 1: caesar is executing or has an outstanding transaction.
- `req_i`, in, 1: bus/host request targeting caesar. Held until `gnt_o`.
- `gnt_o`, out, 1: request accepted; the caesar clock is running and settled.
- `force_en_i`, in, 1: software override; keeps or brings the clock on.
- `clk_en_o`, out, 1: enable to the clock-gating cell.
- `gated_o`, out, 1: status; the clock is currently gated.
- `stat_clr_i`, in, 1: synchronous clear of `gated_cycles_o`.
- `gated_cycles_o`, out, STAT_W: saturating count of cycles spent in GATED.

## Operation
- The FSM has four states: ON, IDLE_WAIT, GATED, WAKE.
- A down-counter `cnt` is sized `$clog2(max(IDLE_CYCLES,WAKE_CYCLES))` bits, minimum 1.
- Define `act = busy_i | req_i | force_en_i`.

State behaviour:
- **ON:** if `!act`, go to IDLE_WAIT and load `cnt = IDLE_CYCLES-1`. Otherwise stay in ON.
- **IDLE_WAIT:** if `act`, go to ON; activity always wins over expiry. Else if `cnt==0`, go to GATED. Else decrement `cnt`.
- **GATED:** if `req_i | force_en_i`, go to WAKE and load `cnt = WAKE_CYCLES-1`. `busy_i` is ignored here, because caesar cannot become busy while unclocked.
- **WAKE:** if `cnt==0`, go to ON. Else decrement `cnt`. Inputs are ignored until ON is reached.

Outputs:
- `clk_en_o = (state != GATED)`. It is decoded from the state register only, never from inputs, so it is glitch-free.
- `gated_o = (state == GATED)`.
- `gnt_o = req_i & (state ∈ {ON, IDLE_WAIT})`. This is combinational from `req_i`. No grant is issued in GATED or WAKE.

Statistics counter:
- `gated_cycles_o` increments by 1 every cycle that state is GATED.
- It saturates at all-ones.
- `stat_clr_i` has priority over increment: the counter reads 0 on the next cycle.

Reset:
- `rst_i` forces state ON, `cnt=0`, `gated_cycles_o=0`.
- Resulting output values: `clk_en_o=1`, `gated_o=0`, `gnt_o=0` (unless `req_i` is high while in ON).
- Reset in any state, including GATED and WAKE, takes effect at the next edge. The clock is re-enabled immediately, with no WAKE window, so that caesar receives its own reset.

## Timing
- **Gating latency:** `act` falls in cycle t while in ON → IDLE_WAIT during cycles t+1 … t+IDLE_CYCLES → GATED from cycle t+1+IDLE_CYCLES. `clk_en_o` is first 0 in that cycle.
- **Idle abort:** `act` seen in any IDLE_WAIT cycle → ON next cycle. The hysteresis restarts in full on the next idle period.
- **Wake latency:** `req_i` rises in cycle w while in GATED → `clk_en_o=1` at w+1 → WAKE for WAKE_CYCLES cycles → ON at w+1+WAKE_CYCLES. `gnt_o=1` in that same cycle if `req_i` is held.
- **Minimum wake-to-grant:** 1+WAKE_CYCLES cycles. Requests arriving in ON or IDLE_WAIT have 0-cycle grant latency.
- **Simultaneous events:**
  - `act` together with `cnt==0` in IDLE_WAIT → ON.
  - `stat_clr_i` together with the GATED increment → counter reads 0.
  - `force_en_i` held high → the FSM never leaves ON.

## Structure
- Shared package `caesar_clk_gate_pkg` holds:
  - the state enum `caesar_cg_state_e` (ON, IDLE_WAIT, GATED, WAKE);
  - the default constants `CAESAR_CG_IDLE_CYCLES=16` and `CAESAR_CG_WAKE_CYCLES=2`.
- One sub-module, `caesar_cg_sat_counter`, is natural: a parameterised saturating counter with clear/enable, used for `gated_cycles_o`.
- The FSM and `cnt` stay in the top module.
- The controller instantiates no clock cell itself. It is placed beside the clock-gate wrapper, with `clk_en_o` driving that wrapper's enable input.

## Test plan
1. **Reset and gating.** Release reset with all inputs 0 and IDLE_CYCLES=16. Expect `clk_en_o=1` for 17 cycles after reset release, then `clk_en_o=0` and `gated_o=1`; `gated_cycles_o` then increments by 1 per cycle.
2. **Wake on request.** In GATED, raise and hold `req_i` with WAKE_CYCLES=2. Expect `clk_en_o=1` one cycle later, `gnt_o=0` for 3 cycles, then `gnt_o=1` exactly at the entry to ON.
3. **Idle abort.** Pulse `busy_i` for 1 cycle at IDLE_WAIT cycle 15, coinciding with `cnt==0`. Expect a return to ON with `clk_en_o` never dropping; after `busy_i` falls, a full 16-cycle hysteresis runs before gating.
4. **Force override.** With `force_en_i=1` held for 100 idle cycles, expect `clk_en_o=1` throughout. With `force_en_i` raised while GATED, expect WAKE followed by ON.
5. **Reset mid-operation.** Assert `rst_i` in GATED with `gated_cycles_o=40`. Expect `clk_en_o=1`, `gated_o=0` and `gated_cycles_o=0` on the next cycle, with no WAKE window.
6. **Counter saturation.** With STAT_W=4, stay GATED for 20 cycles. Expect `gated_cycles_o` to hold at 15; `stat_clr_i` held across one GATED cycle gives 0 on the following cycle.
